// File: rtl/apb_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : apb_req_scheduler
// Brief   : Round-robin scheduler sharing one APB master among N requesters,
//           with a per-transfer watchdog and a saturating stall counter.
// Rev     : 1.0  initial release
// ============================================================================

module apb_req_scheduler #(
   parameter int N       = 4,
   parameter int M       = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic [N-1:0]         req_valid,
   input  logic [N*M-1:0]       req_data,
   input  logic [2*N-1:0]       req_sel,
   input  logic [N-1:0]         req_err,
   output logic [N-1:0]         req_ready,
   output logic [N-1:0]         req_done,
   output logic [N-1:0]         req_timeout,
   output logic [M-1:0]         o_data,
   output logic                 o_data_ready,
   output logic [1:0]           o_protocol_sel,
   output logic                 o_alu_error,
   input  logic                 i_waiting,
   input  logic                 i_transfer_done,
   output logic                 o_busy,
   output logic [$clog2(N)-1:0] o_grant,
   output logic [7:0]           o_stall_cnt
);

   localparam int GW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [N-1:0]  c_one      = N'(1);
   localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_last;
   logic [CW-1:0]   r_cnt;

   logic [M-1:0]    w_data [N];
   logic [1:0]      w_sel  [N];
   logic [GW-1:0]   w_idx;
   logic [GW-1:0]   w_pick;
   logic            w_found;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         w_data[k] = req_data[k*M +: M];
         w_sel[k]  = req_sel[2*k +: 2];
      end
   end

   // Search starts just after the last granted requester and wraps around.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int i = 1; i <= N; i++) begin
         w_idx = GW'((int'(r_last) + i) % N);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_state        <= S_IDLE;
         r_last         <= GW'(N - 1);
         r_cnt          <= '0;
         req_ready      <= '0;
         req_done       <= '0;
         req_timeout    <= '0;
         o_data         <= '0;
         o_data_ready   <= 1'b0;
         o_protocol_sel <= '0;
         o_alu_error    <= 1'b0;
         o_busy         <= 1'b0;
         o_grant        <= '0;
         o_stall_cnt    <= '0;
      end else begin
         req_ready    <= '0;
         req_done     <= '0;
         req_timeout  <= '0;
         o_data_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  req_ready      <= c_one << w_pick;
                  o_grant        <= w_pick;
                  o_data         <= w_data[w_pick];
                  o_protocol_sel <= w_sel[w_pick];
                  o_alu_error    <= req_err[w_pick];
                  o_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               o_data_ready <= 1'b1;
               r_cnt        <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (i_waiting && (o_stall_cnt != 8'hFF)) begin
                  o_stall_cnt <= o_stall_cnt + 8'd1;
               end
               // A completion in the watchdog's last cycle still counts as done.
               if (i_transfer_done) begin
                  req_done <= c_one << o_grant;
                  r_state  <= S_DONE;
               end else if (r_cnt == c_cnt_last) begin
                  req_timeout <= c_one << o_grant;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_last      <= o_grant;
               o_alu_error <= 1'b0;
               o_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
